// File: rtl/cpu_mem_responder.sv
// Single-port-per-master memory responder: a read-only fetch port and a load/store port
// sharing one word RAM, plus a small MMIO block (GPIO, cycle counter, error counter).
module cpu_mem_responder #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_pc_addr,
  input  logic        i_pc_rd,
  output logic [15:0] o_pc_rddata,
  input  logic [15:0] i_ldst_addr,
  input  logic        i_ldst_rd,
  input  logic        i_ldst_wr,
  input  logic [15:0] i_ldst_wrdata,
  output logic [15:0] o_ldst_rddata,
  output logic [15:0] o_gpio,
  output logic [7:0]  o_err_count
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [15:0] DEPTH_W   = 16'(DEPTH_WORDS);
  localparam logic [15:0] MMIO_BASE = 16'hFFF0;

  typedef enum logic [1:0] {REGION_RAM, REGION_MMIO, REGION_OOR} region_e;

  // Byte address -> region; bit 0 never matters, so odd addresses alias their word.
  function automatic region_e decode(input logic [15:0] addr);
    if (addr >= MMIO_BASE)              return REGION_MMIO;
    if ({1'b0, addr[15:1]} < DEPTH_W)   return REGION_RAM;
    return REGION_OOR;
  endfunction

  logic [15:0]   mem [DEPTH_WORDS];
  logic [15:0]   gpio_q;
  logic [15:0]   cycle_q;
  logic [7:0]    err_q;

  region_e       pc_region;
  region_e       ls_region;
  logic [AW-1:0] pc_idx;
  logic [AW-1:0] ls_idx;
  logic          ram_we;
  logic          mmio_we;
  logic          fetch_fwd;
  logic [1:0]    new_errs;
  logic [8:0]    err_sum;
  logic [7:0]    err_d;
  logic [15:0]   mmio_rddata;
  logic [15:0]   pc_rddata_d;
  logic [15:0]   ls_rddata_d;

  assign pc_region = decode(i_pc_addr);
  assign ls_region = decode(i_ldst_addr);
  assign pc_idx    = i_pc_addr[AW:1];
  assign ls_idx    = i_ldst_addr[AW:1];

  // Stores are suppressed while reset is high, including the edge on which it releases.
  assign ram_we    = i_ldst_wr && (ls_region == REGION_RAM) && !reset;
  assign mmio_we   = i_ldst_wr && (ls_region == REGION_MMIO);
  assign fetch_fwd = ram_we && (pc_region == REGION_RAM) && (pc_idx == ls_idx);

  assign new_errs  = {1'b0, i_pc_rd && (pc_region != REGION_RAM)}
                   + {1'b0, (i_ldst_rd || i_ldst_wr) && (ls_region == REGION_OOR)};
  assign err_sum   = {1'b0, err_q} + {7'b0, new_errs};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    mmio_rddata = '0;
    case (i_ldst_addr[3:1])
      3'd0:    mmio_rddata = gpio_q;
      3'd1:    mmio_rddata = cycle_q;
      3'd2:    mmio_rddata = {8'h00, err_q};
      default: mmio_rddata = '0;
    endcase
  end

  always_comb begin
    pc_rddata_d = '0;
    if (pc_region == REGION_RAM)
      pc_rddata_d = fetch_fwd ? i_ldst_wrdata : mem[pc_idx];
  end

  always_comb begin
    ls_rddata_d = '0;
    case (ls_region)
      REGION_RAM:  ls_rddata_d = mem[ls_idx];
      REGION_MMIO: ls_rddata_d = mmio_rddata;
      default:     ls_rddata_d = '0;
    endcase
  end

  // A coincident ERR write-clear restarts the count from this cycle's new errors.
  always_comb begin
    err_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    if (mmio_we && (i_ldst_addr[3:1] == 3'd2))
      err_d = {6'b0, new_errs};
  end

  // NOTE: the RAM has no reset so it maps onto plain memory and survives a reset pulse.
  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ls_idx] <= i_ldst_wrdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      o_pc_rddata   <= '0;
      o_ldst_rddata <= '0;
      gpio_q        <= '0;
      cycle_q       <= '0;
      err_q         <= '0;
    end else begin
      if (i_pc_rd)
        o_pc_rddata <= pc_rddata_d;
      if (i_ldst_rd)
        o_ldst_rddata <= ls_rddata_d;
      if (mmio_we && (i_ldst_addr[3:1] == 3'd0))
        gpio_q <= i_ldst_wrdata;
      if (mmio_we && (i_ldst_addr[3:1] == 3'd1))
        cycle_q <= '0;
      else
        cycle_q <= cycle_q + 16'd1;
      err_q <= err_d;
    end
  end

  assign o_gpio      = gpio_q;
  assign o_err_count = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized bench for cpu_mem_responder (16-word RAM) checked against a
// transaction-level reference model of the memory map.
module tb_cpu_mem_responder;

  logic        clk;
  logic        reset;
  logic [15:0] i_pc_addr;
  logic        i_pc_rd;
  logic [15:0] o_pc_rddata;
  logic [15:0] i_ldst_addr;
  logic        i_ldst_rd;
  logic        i_ldst_wr;
  logic [15:0] i_ldst_wrdata;
  logic [15:0] o_ldst_rddata;
  logic [15:0] o_gpio;
  logic [7:0]  o_err_count;

  cpu_mem_responder #(.DEPTH_WORDS(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_pc_addr     (i_pc_addr),
    .i_pc_rd       (i_pc_rd),
    .o_pc_rddata   (o_pc_rddata),
    .i_ldst_addr   (i_ldst_addr),
    .i_ldst_rd     (i_ldst_rd),
    .i_ldst_wr     (i_ldst_wr),
    .i_ldst_wrdata (i_ldst_wrdata),
    .o_ldst_rddata (o_ldst_rddata),
    .o_gpio        (o_gpio),
    .o_err_count   (o_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what the memory map should hold after each edge.
  logic [15:0] m_mem [16];
  logic [15:0] m_gpio;
  logic [15:0] m_cycle;
  logic [15:0] m_pc;
  logic [15:0] m_ld;
  int          m_err;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // 0 = RAM, 1 = MMIO, 2 = out of range
  function automatic int region_of(input logic [15:0] a);
    if (a >= 16'hFFF0)     return 1;
    if (a[15:1] < 15'd16)  return 0;
    return 2;
  endfunction

  function automatic logic [15:0] mmio_value(input logic [15:0] a);
    case (a & 16'hFFFE)
      16'hFFF0: return m_gpio;
      16'hFFF2: return m_cycle;
      16'hFFF4: return 16'(m_err);
      default:  return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 16'($urandom_range(0, 31));
      2:       return 16'hFFF0 + 16'($urandom_range(0, 15));
      default: return 16'($urandom_range(32, 32'hFFEF));
    endcase
  endfunction

  task automatic model_reset();
    m_gpio  = '0;
    m_cycle = '0;
    m_pc    = '0;
    m_ld    = '0;
    m_err   = 0;
  endtask

  // One clock: drive inputs, predict, advance past the edge, compare.
  task automatic step(input logic pc_rd, input logic [15:0] pc_addr,
                      input logic rd, input logic wr,
                      input logic [15:0] ls_addr, input logic [15:0] wrdata);
    int          rpc, rls, nerr;
    logic [15:0] nxt_pc, nxt_ld;
    logic        clr_cyc, clr_err;
    i_pc_rd       = pc_rd;
    i_pc_addr     = pc_addr;
    i_ldst_rd     = rd;
    i_ldst_wr     = wr;
    i_ldst_addr   = ls_addr;
    i_ldst_wrdata = wrdata;

    rpc  = region_of(pc_addr);
    rls  = region_of(ls_addr);
    nerr = 0;
    if (pc_rd && rpc != 0)         nerr++;
    if ((rd || wr) && rls == 2)    nerr++;

    nxt_pc = m_pc;
    if (pc_rd) begin
      if (rpc != 0)
        nxt_pc = 16'h0000;
      else if (wr && rls == 0 && ls_addr[15:1] == pc_addr[15:1])
        nxt_pc = wrdata;
      else
        nxt_pc = m_mem[pc_addr[4:1]];
    end
    nxt_ld = m_ld;
    if (rd) begin
      if (rls == 0)      nxt_ld = m_mem[ls_addr[4:1]];
      else if (rls == 1) nxt_ld = mmio_value(ls_addr);
      else               nxt_ld = 16'h0000;
    end
    clr_cyc = wr && ((ls_addr & 16'hFFFE) == 16'hFFF2);
    clr_err = wr && ((ls_addr & 16'hFFFE) == 16'hFFF4);

    @(posedge clk);
    #1;
    if (wr && rls == 0)                            m_mem[ls_addr[4:1]] = wrdata;
    if (wr && ((ls_addr & 16'hFFFE) == 16'hFFF0))  m_gpio = wrdata;
    m_cycle = clr_cyc ? 16'h0000 : m_cycle + 16'd1;
    if (clr_err)                 m_err = nerr;
    else if (m_err + nerr > 255) m_err = 255;
    else                         m_err = m_err + nerr;
    m_pc = nxt_pc;
    m_ld = nxt_ld;

    check("pc_rddata", o_pc_rddata, m_pc);
    check("ldst_rddata", o_ldst_rddata, m_ld);
    check("gpio", o_gpio, m_gpio);
    check("err_count", {8'h00, o_err_count}, 16'(m_err));
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    int guard;
    reset = 1'b0; i_pc_rd = 1'b0; i_pc_addr = '0;
    i_ldst_rd = 1'b0; i_ldst_wr = 1'b0; i_ldst_addr = '0; i_ldst_wrdata = '0;
    model_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_pc", o_pc_rddata, 16'h0000);
    check("rst_ld", o_ldst_rddata, 16'h0000);
    check("rst_gpio", o_gpio, 16'h0000);
    check("rst_err", {8'h00, o_err_count}, 16'h0000);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // First strobe after reset: cycle counter sampled at its first edge reads 0.
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'hFFF2, 16'h0);
    check("first_read", o_ldst_rddata, 16'h0000);

    for (int i = 0; i < 16; i++)
      step(1'b0, 16'h0, 1'b0, 1'b1, 16'(2 * i), 16'($urandom));

    // Store then load through the odd alias of the same word.
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0011, 16'h0);
    check("store_load", o_ldst_rddata, 16'hBEEF);

    // Write-first fetch forwarding, read-first load on rd+wr.
    step(1'b1, 16'h001C, 1'b0, 1'b1, 16'h001C, 16'h1234);
    check("fetch_fwd", o_pc_rddata, 16'h1234);
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h001C, 16'h5678);
    check("rd_first", o_ldst_rddata, 16'h1234);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h001C, 16'h0);
    check("after_rdwr", o_ldst_rddata, 16'h5678);
    idle();
    check("ld_hold", o_ldst_rddata, 16'h5678);

    step(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFF0, 16'hA5A5);
    check("gpio_wr", o_gpio, 16'hA5A5);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFF4, 16'h0);
    check("err_clr", {8'h00, o_err_count}, 16'h0000);

    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0);
    check("oor_data", o_ldst_rddata, 16'h0000);
    check("oor_err1", {8'h00, o_err_count}, 16'h0001);
    for (int i = 0; i < 299; i++)
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0);
    check("err_sat", {8'h00, o_err_count}, 16'h00FF);

    // Depth boundary: word 15 is RAM, word 16 is not.
    step(1'b1, 16'h001F, 1'b1, 1'b0, 16'h0020, 16'h0);
    check("oor_word16", o_ldst_rddata, 16'h0000);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFF4, 16'h0);
    step(1'b1, 16'hFFF4, 1'b1, 1'b0, 16'h0030, 16'h0);
    check("err_two", {8'h00, o_err_count}, 16'h0002);
    step(1'b1, 16'h0040, 1'b0, 1'b1, 16'hFFF4, 16'h0);
    check("clr_plus_err", {8'h00, o_err_count}, 16'h0001);
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFF8, 16'h7777);
    check("mmio_unused", o_ldst_rddata, 16'h0000);

    // Cycle counter: clear, five edges, then sample.
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFF2, 16'h0);
    repeat (5) idle();
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'hFFF2, 16'h0);
    check("cycle5", o_ldst_rddata, 16'h0005);
    guard = 0;
    while (m_cycle != 16'hFFFE && guard < 70000) begin
      idle();
      guard++;
    end
    repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0, 16'hFFF2, 16'h0);
    check("cycle_wrap", o_ldst_rddata, 16'h0000);

    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0), rand_addr(), 16'($urandom));

    // Reset in the middle of traffic with a store pending.
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0006, 16'h3C3C);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFF0, 16'h00FF);
    step(1'b1, 16'h0006, 1'b1, 1'b0, 16'h0006, 16'h0);
    i_ldst_wr = 1'b1; i_ldst_addr = 16'h0006; i_ldst_wrdata = 16'hDEAD;
    i_pc_rd = 1'b1; i_ldst_rd = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_pc", o_pc_rddata, 16'h0000);
    check("mid_rst_ld", o_ldst_rddata, 16'h0000);
    check("mid_rst_gpio", o_gpio, 16'h0000);
    check("mid_rst_err", {8'h00, o_err_count}, 16'h0000);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    i_ldst_wr = 1'b0; i_pc_rd = 1'b0; i_ldst_rd = 1'b0;
    reset = 1'b0;
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0006, 16'h0);
    check("ram_kept", o_ldst_rddata, 16'h3C3C);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'hFFF2, 16'h0);
    check("cycle_after_rst", o_ldst_rddata, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096: number of 16-bit RAM words; legal range 1..32760.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 i_pc_addr  in  16  instruction fetch byte address.
REQ-005 i_pc_rd  in  1  fetch read strobe.
REQ-006 o_pc_rddata  out  16  fetched instruction word.
REQ-007 i_ldst_addr  in  16  load/store byte address.
REQ-008 i_ldst_rd  in  1  load strobe.
REQ-009 i_ldst_wr  in  1  store strobe.
REQ-010 i_ldst_wrdata  in  16  store data.
REQ-011 o_ldst_rddata  out  16  load data.
REQ-012 o_gpio  out  16  GPIO output register.
REQ-013 o_err_count  out  8  saturating count of illegal accesses.

Function
REQ-014 Word index SHALL be addr[15:1]; addr[0] SHALL be ignored, with no error raised.
REQ-015 RAM region: addr < 16'hFFF0 and word index < DEPTH_WORDS.
REQ-016 MMIO region: addr 16'hFFF0..16'hFFFF.
REQ-017 Anything else SHALL be out-of-range.
REQ-018 Read latency SHALL be exactly 1 cycle: strobe plus address sampled at edge N, data valid after edge N and held until the next accepted read.
REQ-019 With the strobe low, the read data output SHALL hold its last value.
REQ-020 Fetch port is read-only and SHALL be serviced every cycle i_pc_rd=1, with no stall or backpressure.
REQ-021 A store SHALL update RAM at the edge it is sampled.
REQ-022 Fetch and store to the same RAM word in the same cycle: o_pc_rddata SHALL return the newly written data (write-first forwarding).
REQ-023 i_ldst_rd and i_ldst_wr both high: the write SHALL be performed and o_ldst_rddata SHALL return the pre-write contents (read-first on the data port).
REQ-024 MMIO map, data port only:
  - 16'hFFF0 GPIO: R/W, drives o_gpio.
  - 16'hFFF2 CYCLE: free-running 16-bit cycle counter, wraps FFFF->0000; read returns value at the sampling edge; write clears it to 0 at that edge.
  - 16'hFFF4 ERR: reads {8'h00, o_err_count}; write clears the count to 0.
  - Other MMIO addresses: reads return 0, writes ignored, no error.
REQ-025 Out-of-range load or store, or a fetch whose address is in MMIO or out-of-range:
  - read data SHALL be 16'h0000;
  - write SHALL be dropped;
  - o_err_count SHALL increment by 1 per offending port per cycle (up to +2), saturating at 8'hFF.
REQ-026 ERR write-clear coinciding with a new error: result SHALL be the number of new errors that cycle (1 or 2).
REQ-027 RAM contents are not reset and are undefined until written.

Reset
REQ-028 Reset SHALL asynchronously force these outputs to 0: o_pc_rddata, o_ldst_rddata, o_gpio, o_err_count, and the cycle counter.
REQ-029 A store sampled at the same edge that reset is released SHALL NOT be performed.
REQ-030 Reset asserted mid-operation SHALL abort any pending read result; RAM contents SHALL be preserved.
REQ-031 First valid read data SHALL appear 1 cycle after the first strobe following reset release.

Verification
REQ-032 Store 16'hBEEF to 16'h0010, then load 16'h0011 next cycle -> o_ldst_rddata = 16'hBEEF one cycle after the load.
REQ-033 Same cycle: fetch 16'h0020 and store 16'h1234 to 16'h0020 -> o_pc_rddata = 16'h1234; ldst rd+wr to 16'h0020 with 16'h5678 -> o_ldst_rddata = 16'h1234, and a later load returns 16'h5678.
REQ-034 DEPTH_WORDS=16: load 16'h0040 -> data 0 and o_err_count=1; repeat 300 times -> o_err_count = 8'hFF.
REQ-035 Store 16'hA5A5 to 16'hFFF0 -> o_gpio = 16'hA5A5 next cycle; store to 16'hFFF4 -> o_err_count = 0.
REQ-036 Write 16'hFFF2, wait 5 cycles, load 16'hFFF2 -> 5; let the counter pass 16'hFFFF -> observed wrap to 0.
REQ-037 Assert reset mid-stream with i_ldst_wr high -> all outputs 0 immediately, store dropped, earlier RAM data intact after release.
